// File: rtl/ldpc_phase_scheduler.sv
// LDPC phase scheduler: sequences CNU/VNU phases and drives the shared read/write address streams and the ping-pong bank select.
// Define LDPC_SCHED_EARLY_TERM_EN to finish a frame early when parity_ok is high in the last VNU drain cycle.
module ldpc_phase_scheduler #(
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32,
  parameter int COUNT_FROM = 0,
  parameter int CNU_DELAY  = 5,
  parameter int VNU_DELAY  = 3,
  parameter int MAX_ITER   = 18,
  parameter int ITER_W     = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  start_ready,
  output logic                  enable_cnu,
  output logic                  vnu_en,
  output logic [ADDR_WIDTH-1:0] read_add,
  output logic                  read_valid,
  output logic [ADDR_WIDTH-1:0] write_add,
  output logic                  write_valid,
  output logic                  rs,
  output logic [ITER_W-1:0]     itr_count,
  output logic                  busy,
  output logic                  done,
  input  logic                  parity_ok
);

  localparam int MAX_DELAY = (CNU_DELAY > VNU_DELAY) ? CNU_DELAY : VNU_DELAY;
  localparam int CNT_SPAN  = (DEPTH > MAX_DELAY) ? DEPTH : MAX_DELAY;
  localparam int CNT_W     = (CNT_SPAN > 1) ? $clog2(CNT_SPAN) : 1;

  localparam logic [CNT_W-1:0]      DEPTH_LAST = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]      CNU_LAST   = CNT_W'(CNU_DELAY - 1);
  localparam logic [CNT_W-1:0]      VNU_LAST   = CNT_W'(VNU_DELAY - 1);
  localparam logic [ITER_W-1:0]     ITER_LAST  = ITER_W'(MAX_ITER - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_BASE  = ADDR_WIDTH'(COUNT_FROM);

  typedef enum logic [2:0] {
    IDLE,
    CNU_RD,
    CNU_DRN,
    VNU_RD,
    VNU_DRN,
    FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ITER_W-1:0] itr_q, itr_d;
  logic              rs_q, rs_d;
  logic              early_term;
  logic              phase_entry;

  logic [ADDR_WIDTH-1:0] dly_add_q [MAX_DELAY];
  logic [MAX_DELAY-1:0]  dly_vld_q;

`ifdef LDPC_SCHED_EARLY_TERM_EN
  assign early_term = parity_ok;
`else
  logic parity_unused;
  assign parity_unused = parity_ok;
  assign early_term    = 1'b0;
`endif

  // NOTE: every variable gets a default before the case so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    itr_d   = itr_q;
    rs_d    = rs_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CNU_RD;
          cnt_d   = '0;
          itr_d   = '0;
        end
      end
      CNU_RD: begin
        if (cnt_q == DEPTH_LAST) begin
          state_d = CNU_DRN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CNU_DRN: begin
        if (cnt_q == CNU_LAST) begin
          state_d = VNU_RD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      VNU_RD: begin
        if (cnt_q == DEPTH_LAST) begin
          state_d = VNU_DRN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      VNU_DRN: begin
        if (cnt_q == VNU_LAST) begin
          cnt_d = '0;
          itr_d = itr_q + ITER_W'(1);
          // The iteration completing now is the last one when the pre-increment count is MAX_ITER-1.
          if ((itr_q == ITER_LAST) || early_term) begin
            state_d = FINISH;
            rs_d    = ~rs_q;
          end else begin
            state_d = CNU_RD;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      itr_q   <= '0;
      rs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      itr_q   <= itr_d;
      rs_q    <= rs_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign enable_cnu  = (state_q == CNU_RD) || (state_q == CNU_DRN);
  assign vnu_en      = (state_q == VNU_RD) || (state_q == VNU_DRN);
  assign busy        = enable_cnu || vnu_en;
  assign done        = (state_q == FINISH);
  assign read_valid  = (state_q == CNU_RD) || (state_q == VNU_RD);
  assign read_add    = ADDR_BASE + ADDR_WIDTH'(cnt_q);
  assign rs          = rs_q;
  assign itr_count   = itr_q;

  // Stale valids from the previous phase would leak through a longer tap, so the line is flushed on every phase entry.
  assign phase_entry = (state_d != state_q) && ((state_d == CNU_RD) || (state_d == VNU_RD));

  // NOTE: the delay line is small and its contents are visible on write_add, so it is reset rather than left unknown.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_DELAY; i++) dly_add_q[i] <= ADDR_BASE;
      dly_vld_q <= '0;
    end else begin
      dly_add_q[0] <= read_add;
      for (int i = 1; i < MAX_DELAY; i++) dly_add_q[i] <= dly_add_q[i-1];
      if (phase_entry) dly_vld_q <= '0;
      else             dly_vld_q <= (dly_vld_q << 1) | MAX_DELAY'(read_valid);
    end
  end

  assign write_add   = vnu_en ? dly_add_q[VNU_DELAY-1] : dly_add_q[CNU_DELAY-1];
  assign write_valid = busy && (vnu_en ? dly_vld_q[VNU_DELAY-1] : dly_vld_q[CNU_DELAY-1]);

endmodule

// File: tb/tb_ldpc_phase_scheduler.sv
// Scoreboard bench for ldpc_phase_scheduler: a frame-level schedule model predicts every read, write and done event.
module tb_ldpc_phase_scheduler;

  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int CF    = 0;
  localparam int CD    = 5;
  localparam int VD    = 3;
  localparam int MAXI  = 18;
  localparam int IW    = 6;
  localparam int L     = 2 * DEPTH + CD + VD;
  localparam int NONE  = MAXI + 1;

`ifdef LDPC_SCHED_EARLY_TERM_EN
  localparam int ET_LEN = 2 * L + 1;
  localparam int ET_ITR = 2;
`else
  localparam int ET_LEN = MAXI * L + 1;
  localparam int ET_ITR = MAXI;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic parity_ok = 1'b0;
  logic start_ready, enable_cnu, vnu_en, read_valid, write_valid, rs, busy, done;
  logic [AW-1:0] read_add, write_add;
  logic [IW-1:0] itr_count;

  logic w_start = 1'b0;
  logic w_parity = 1'b0;
  logic w_start_ready, w_enable_cnu, w_vnu_en, w_read_valid, w_write_valid, w_rs, w_busy, w_done;
  logic [4:0] w_read_add, w_write_add;
  logic [2:0] w_itr_count;

  ldpc_phase_scheduler #(
    .ADDR_WIDTH(AW), .DEPTH(DEPTH), .COUNT_FROM(CF), .CNU_DELAY(CD),
    .VNU_DELAY(VD), .MAX_ITER(MAXI), .ITER_W(IW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .start_ready(start_ready),
    .enable_cnu(enable_cnu), .vnu_en(vnu_en), .read_add(read_add),
    .read_valid(read_valid), .write_add(write_add), .write_valid(write_valid),
    .rs(rs), .itr_count(itr_count), .busy(busy), .done(done), .parity_ok(parity_ok)
  );

  ldpc_phase_scheduler #(
    .ADDR_WIDTH(5), .DEPTH(4), .COUNT_FROM(30), .CNU_DELAY(2),
    .VNU_DELAY(1), .MAX_ITER(2), .ITER_W(3)
  ) dut_w (
    .clk(clk), .reset(reset), .start(w_start), .start_ready(w_start_ready),
    .enable_cnu(w_enable_cnu), .vnu_en(w_vnu_en), .read_add(w_read_add),
    .read_valid(w_read_valid), .write_add(w_write_add), .write_valid(w_write_valid),
    .rs(w_rs), .itr_count(w_itr_count), .busy(w_busy), .done(w_done), .parity_ok(w_parity)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int addr;
    bit cnu;
    int itr;
    bit rs;
  } xfer_t;

  typedef struct {
    int cyc;
    int itr;
    bit rs_after;
  } done_t;

  xfer_t rq[$];
  xfer_t wq[$];
  done_t dq[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: current frame window, bank, parity plan.
  int fb = 0;
  int fe = -1;
  bit m_rs = 1'b0;
  int cur_s = -1;
  int cur_p = 0;
  int idle_from = 0;
  int force_p = 0;
  int n_accepts = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_frame(input int s, input int n);
    int base;
    int a;
    for (int it = 0; it < n; it++) begin
      base = s + 1 + it * L;
      for (int i = 0; i < DEPTH; i++) begin
        a = (CF + i) % (1 << AW);
        rq.push_back(xfer_t'{base + i, a, 1'b1, it, m_rs});
        wq.push_back(xfer_t'{base + CD + i, a, 1'b1, it, m_rs});
      end
      for (int i = 0; i < DEPTH; i++) begin
        a = (CF + i) % (1 << AW);
        rq.push_back(xfer_t'{base + DEPTH + CD + i, a, 1'b0, it, m_rs});
        wq.push_back(xfer_t'{base + DEPTH + CD + VD + i, a, 1'b0, it, m_rs});
      end
    end
  endtask

  task automatic accept(input int s);
    int p;
    int n;
    p = (force_p != 0) ? force_p : int'($urandom_range(1, MAXI + 3));
`ifdef LDPC_SCHED_EARLY_TERM_EN
    n = (p <= MAXI) ? p : MAXI;
`else
    n = MAXI;
`endif
    push_frame(s, n);
    dq.push_back(done_t'{s + 1 + n * L, n, ~m_rs});
    m_rs      = ~m_rs;
    fb        = s + 1;
    fe        = s + 1 + n * L;
    idle_from = fe + 1;
    cur_s     = s;
    cur_p     = p;
    n_accepts++;
  endtask

  // parity_ok is high for the whole planned iteration, low at other iterations' sample points, random elsewhere.
  function automatic bit parity_for(input int c);
    int k;
    if (cur_s >= 0 && c > cur_s && c < fe) begin
      k = c - cur_s;
      if ((k - 1) / L + 1 == cur_p) return 1'b1;
      if (k % L == 0) return 1'b0;
    end
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic tick(input bit want);
    @(posedge clk);
    #1;
    start = want;
    if (want && cyc >= idle_from) accept(cyc);
    parity_ok = parity_for(cyc);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000 && cyc < idle_from; i++) tick(1'b0);
    if (cyc < idle_from) check("idle_timeout", 0, 1);
  endtask

  task automatic wait_done(input int bound, output int f, output int itr);
    f   = -1;
    itr = -1;
    for (int i = 0; i < bound; i++) begin
      tick(1'b0);
      if (done) begin
        f   = cyc;
        itr = itr_count;
        break;
      end
    end
    if (f < 0) check("done_timeout", 0, 1);
  endtask

  task automatic check_reset_values();
    check("rst_start_ready", start_ready, 1);
    check("rst_enable_cnu", enable_cnu, 0);
    check("rst_vnu_en", vnu_en, 0);
    check("rst_read_valid", read_valid, 0);
    check("rst_write_valid", write_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rs", rs, 0);
    check("rst_itr_count", itr_count, 0);
    check("rst_read_add", read_add, CF);
    check("rst_write_add", write_add, CF);
  endtask

  task automatic wrap_test();
    int ws;
    int f;
    int itr;
    int rd[$];
    int wr[$];
    int wrap_exp[4];
    wrap_exp = '{30, 31, 0, 1};
    tick(1'b0);
    w_start = 1'b1;
    ws      = cyc;
    for (int k = 1; k <= 6; k++) begin
      tick(1'b0);
      w_start = 1'b0;
      if (w_read_valid && w_enable_cnu) rd.push_back(int'(w_read_add));
      if (w_write_valid) wr.push_back(int'(w_write_add));
    end
    check("wrap_read_count", rd.size(), 4);
    check("wrap_write_count", wr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < rd.size()) check("wrap_read_add", rd[i], wrap_exp[i]);
      if (i < wr.size()) check("wrap_write_add", wr[i], wrap_exp[i]);
    end
    f   = -1;
    itr = -1;
    for (int i = 0; i < 60; i++) begin
      tick(1'b0);
      if (w_done) begin
        f   = cyc;
        itr = w_itr_count;
        break;
      end
    end
    check("wrap_done_cycle", f - ws, 23);
    check("wrap_done_itr", itr, 2);
  endtask

  // Monitor: pops the expected event whenever the DUT presents one.
  xfer_t mx;
  done_t md;
  bit rs_pend = 1'b0;
  bit rs_exp;
  int itr_exp;

  always @(negedge clk) begin
    if (!reset && mon_en) begin
      check("cnu_vnu_exclusive", enable_cnu & vnu_en, 0);
      check("busy", busy, (cyc >= fb && cyc < fe));
      check("start_ready", start_ready, !(cyc >= fb && cyc <= fe));
      if (read_valid) begin
        check("read_expected", rq.size() != 0, 1);
        if (rq.size() != 0) begin
          mx = rq.pop_front();
          check("read_cycle", cyc, mx.cyc);
          check("read_add", read_add, mx.addr);
          check("read_phase_cnu", enable_cnu, mx.cnu);
          check("read_itr_count", itr_count, mx.itr);
          check("read_rs", rs, mx.rs);
        end
      end
      if (write_valid) begin
        check("write_expected", wq.size() != 0, 1);
        if (wq.size() != 0) begin
          mx = wq.pop_front();
          check("write_cycle", cyc, mx.cyc);
          check("write_add", write_add, mx.addr);
          check("write_phase_cnu", enable_cnu, mx.cnu);
        end
      end
      if (rs_pend) begin
        check("rs_after_done", rs, rs_exp);
        check("itr_held_after_done", itr_count, itr_exp);
        rs_pend = 1'b0;
      end
      if (done) begin
        check("done_expected", dq.size() != 0, 1);
        if (dq.size() != 0) begin
          md = dq.pop_front();
          check("done_cycle", cyc, md.cyc);
          check("done_itr_count", itr_count, md.itr);
          rs_pend = 1'b1;
          rs_exp  = md.rs_after;
          itr_exp = md.itr;
        end
      end
    end
  end

  initial begin
    int s;
    int f;
    int itr;
    int r;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_values();
    mon_en = 1'b1;

    wrap_test();

    // One full frame from a single-cycle start pulse.
    force_p = NONE;
    tick(1'b1);
    s = cyc;
    wait_done(2000, f, itr);
    check("frame_length", f - s, MAXI * L + 1);
    check("frame_itr", itr, MAXI);
    tick(1'b0);
    check("ready_after_finish", start_ready, 1);
    check("rs_after_first", rs, 1);

    // Parity satisfied during iteration 2.
    force_p = 2;
    wait_idle();
    tick(1'b1);
    s = cyc;
    wait_done(2000, f, itr);
    check("early_length", f - s, ET_LEN);
    check("early_itr", itr, ET_ITR);

    // Random start pulses (ignored while busy) and random parity plans.
    force_p = 0;
    for (int i = 0; i < 3000; i++) tick($urandom_range(0, 15) == 0);

    // start held high: the next frame must be taken in the cycle after FINISH.
    force_p = NONE;
    wait_idle();
    s = n_accepts;
    for (int i = 0; i < 4000 && n_accepts < s + 2; i++) tick(1'b1);
    check("held_start_frames", n_accepts - s, 2);
    wait_idle();

    // Reset during VNU_RD of iteration 3, with rs=1 so the clear is visible.
    if (!m_rs) begin
      tick(1'b1);
      wait_idle();
    end
    tick(1'b1);
    s = cyc;
    r = s + 1 + 2 * L + DEPTH + CD + 10;
    for (int i = 0; i < 4 * L && cyc < r - 1; i++) tick(1'b0);
    @(posedge clk);
    #1;
    check("vnu_before_reset", vnu_en, 1);
    reset = 1'b1;
    start = 1'b0;
    rq.delete();
    wq.delete();
    dq.delete();
    rs_pend   = 1'b0;
    fb        = 0;
    fe        = -1;
    cur_s     = -1;
    m_rs      = 1'b0;
    idle_from = cyc + 1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_values();
    for (int i = 0; i < 100; i++) tick(1'b0);

    // A frame after the abort must start from bank 0 again.
    force_p = 0;
    tick(1'b1);
    wait_idle();
    repeat (3) tick(1'b0);

    check("reads_outstanding", rq.size(), 0);
    check("writes_outstanding", wq.size(), 0);
    check("dones_outstanding", dq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ldpc_phase_scheduler.md
Name: ldpc_phase_scheduler

Overview:
- Central controller that sequences the PE block array through alternating CNU and VNU phases for a fixed (or early-terminated) number of decoding iterations.
- Generates the shared read/write address streams, delayed write addresses matching CNU/VNU pipeline latency, phase enables, and the ping-pong frame select `rs`.
- Handshakes with the frame loader: a new intrinsic frame is accepted only when idle. Completion is signalled with a one-cycle `done` pulse.

Parameters:
- ADDR_WIDTH, 5, width of PE RAM addresses.
- DEPTH, 32, addresses swept per phase (1..2^ADDR_WIDTH).
- COUNT_FROM, 0, first address of each sweep; addresses wrap modulo 2^ADDR_WIDTH.
- CNU_DELAY, 5, CNU pipeline latency in clk cycles (>=1).
- VNU_DELAY, 3, VNU pipeline latency in clk cycles (>=1).
- MAX_ITER, 18, iterations per frame (one iteration = CNU phase + VNU phase).
- ITER_W, 6, width of iteration counter (2^ITER_W > MAX_ITER).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  loader has a complete frame in the inactive bank.
- start_ready  out  1  scheduler idle; start accepted when start && start_ready.
- enable_cnu  out  1  1 during CNU phase, 0 otherwise.
- vnu_en  out  1  1 during VNU phase, 0 otherwise.
- read_add  out  ADDR_WIDTH  RAM read address for the current phase.
- read_valid  out  1  read_add valid this cycle.
- write_add  out  ADDR_WIDTH  RAM write address (read_add delayed by the phase delay).
- write_valid  out  1  write_add valid this cycle.
- rs  out  1  frame bank under decode; the loader writes bank !rs.
- itr_count  out  ITER_W  completed iterations of the current/last frame.
- busy  out  1  decoding in progress.
- done  out  1  one-cycle pulse on frame completion.
- parity_ok  in  1  all parity checks satisfied (used only with EARLY_TERM_EN).

Behaviour:
- Reset (sync):
  - State=IDLE; start_ready=1.
  - enable_cnu, vnu_en, read_valid, write_valid, busy, done, rs, itr_count = 0.
  - read_add = write_add = COUNT_FROM.
  - Delay lines are cleared. Reset mid-decode abandons the frame immediately; no done pulse.
- States: IDLE, CNU_RD, CNU_DRN, VNU_RD, VNU_DRN, FINISH.
- IDLE:
  - start_ready=1.
  - On start: itr_count<=0, busy<=1, go to CNU_RD.
  - start is ignored in all other states.
- CNU_RD:
  - Exactly DEPTH cycles; enable_cnu=1, read_valid=1.
  - read_add = COUNT_FROM, COUNT_FROM+1, ... (mod 2^ADDR_WIDTH).
  - Then go to CNU_DRN.
- CNU_DRN:
  - Exactly CNU_DELAY cycles; enable_cnu=1, read_valid=0.
  - Then go to VNU_RD.
- VNU_RD / VNU_DRN:
  - Same as the CNU states with vnu_en=1, enable_cnu=0, and VNU_DELAY.
- End of the last VNU_DRN cycle:
  - itr_count increments.
  - If the new count == MAX_ITER, go to FINISH; else go to CNU_RD.
- Write stream:
  - write_add/write_valid equal read_add/read_valid delayed by exactly CNU_DELAY (CNU phase) or VNU_DELAY (VNU phase) cycles.
  - The last write of a phase falls in the last drain cycle, so writes never cross into the next phase.
  - Delay lines restart on each phase entry.
- Phase length: DEPTH+CNU_DELAY and DEPTH+VNU_DELAY cycles; no idle turnaround cycle between phases.
- FINISH (one cycle):
  - done=1, busy=0, rs toggles, itr_count is held.
  - Next cycle: IDLE.
  - The back-to-back start earliest accepted is the cycle after FINISH.
- itr_count holds its value in IDLE until the next accepted start.
- enable_cnu and vnu_en are never 1 together; both are 0 in IDLE/FINISH.

Optional Feature:
- Macro: LDPC_SCHED_EARLY_TERM_EN.
- Defined:
  - parity_ok is sampled in the last VNU_DRN cycle.
  - If parity_ok=1, go to FINISH after incrementing itr_count, even when itr_count < MAX_ITER.
- Undefined:
  - parity_ok is ignored; exactly MAX_ITER iterations always run.

Test Plan:
- Defaults, reset then start pulse in cycle 0 -> CNU_RD in cycles 1-32 with read_add 0..31; write_valid in cycles 6-37 with write_add 0..31; VNU read_add 0..31 in cycles 38-69.
- Full frame at defaults -> iteration length 72 cycles; done pulses in cycle 1297 with itr_count=18 and rs 0->1; start_ready=1 in cycle 1298.
- COUNT_FROM=30, DEPTH=4 -> read_add sequence 30,31,0,1 (wrap).
- Reset asserted during VNU_RD of iteration 3 -> next cycle IDLE, all outputs at reset values, rs=0, no done.
- start held high through a whole frame -> second frame begins in the cycle after FINISH; rs toggles again at second done.
- LDPC_SCHED_EARLY_TERM_EN defined, parity_ok=1 during iteration 2 -> done in cycle 145, itr_count=2; macro undefined, same stimulus -> itr_count=18.
